clk_div_multi: RTL and testbench

- Parametrised multi-channel clock divider. Successor to the single fixed 24-bit divider.
- Generates CHANNELS independent square-wave outputs and one-cycle tick strobes from one fast CLOCK.
- Each channel has a runtime-programmable divisor, a per-channel enable and a global phase-align SYNC.
- Sits beside the board clock and feeds slow logic: display scanning, debouncers, LED blink.

---
 rtl/clk_div_multi.sv | 133 +++++++++++++
 tb/tb_clk_div_multi.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/clk_div_multi.sv
// Multi-channel programmable clock divider with per-channel enable, global SYNC
// and glitch-free divisor updates. Optional readback port set: CLK_DIV_RDBK_EN.
module clk_div_multi #(
  parameter int unsigned CHANNELS    = 4,
  parameter int unsigned WIDTH       = 24,
  parameter int unsigned DEFAULT_DIV = 12499999,
  localparam int unsigned CH_BITS    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                CLOCK,
  input  logic                RESET_N,
  input  logic [CHANNELS-1:0] EN,
  input  logic                SYNC,
  input  logic                WR_EN,
  input  logic [CH_BITS-1:0]  WR_CH,
  input  logic [WIDTH-1:0]    WR_DATA,
  output logic [CHANNELS-1:0] SLOW,
  output logic [CHANNELS-1:0] TICK
`ifdef CLK_DIV_RDBK_EN
  ,
  input  logic [CH_BITS-1:0]  RD_CH,
  output logic [WIDTH-1:0]    RD_DIV,
  output logic [WIDTH-1:0]    RD_COUNT,
  output logic                RD_PEND
`endif
);

  logic [WIDTH-1:0]    count_q [CHANNELS];
  logic [WIDTH-1:0]    count_d [CHANNELS];
  logic [WIDTH-1:0]    div_q   [CHANNELS];
  logic [WIDTH-1:0]    div_d   [CHANNELS];
  logic [WIDTH-1:0]    pend_q  [CHANNELS];
  logic [WIDTH-1:0]    pend_d  [CHANNELS];
  logic [CHANNELS-1:0] pflag_q, pflag_d;
  logic [CHANNELS-1:0] slow_q, slow_d;
  logic [CHANNELS-1:0] tick_q, tick_d;
  logic [CHANNELS-1:0] apply;

  always_comb begin
    apply   = '0;
    pflag_d = pflag_q;
    slow_d  = slow_q;
    tick_d  = '0;
    for (int unsigned c = 0; c < CHANNELS; c++) begin
      count_d[c] = count_q[c];
      div_d[c]   = div_q[c];
      pend_d[c]  = pend_q[c];
      if (SYNC) begin
        count_d[c] = '0;
        slow_d[c]  = 1'b0;
        apply[c]   = 1'b1;
      end else if (EN[c]) begin
        if (count_q[c] == div_q[c]) begin
          count_d[c] = '0;
          slow_d[c]  = ~slow_q[c];
          tick_d[c]  = 1'b1;
          apply[c]   = 1'b1;
        end else begin
          count_d[c] = count_q[c] + WIDTH'(1);
        end
      end
      // Pending value is consumed before a same-cycle write lands, so the new write stays pending.
      if (apply[c] && pflag_q[c]) begin
        div_d[c]   = pend_q[c];
        pflag_d[c] = 1'b0;
      end
      if (WR_EN && (WR_CH == CH_BITS'(c))) begin
        pend_d[c]  = WR_DATA;
        pflag_d[c] = 1'b1;
      end
    end
  end

  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      for (int unsigned c = 0; c < CHANNELS; c++) begin
        count_q[c] <= '0;
        div_q[c]   <= WIDTH'(DEFAULT_DIV);
        pend_q[c]  <= WIDTH'(DEFAULT_DIV);
      end
      pflag_q <= '0;
      slow_q  <= '0;
      tick_q  <= '0;
    end else begin
      for (int unsigned c = 0; c < CHANNELS; c++) begin
        count_q[c] <= count_d[c];
        div_q[c]   <= div_d[c];
        pend_q[c]  <= pend_d[c];
      end
      pflag_q <= pflag_d;
      slow_q  <= slow_d;
      tick_q  <= tick_d;
    end
  end

  assign SLOW = slow_q;
  assign TICK = tick_q;

`ifdef CLK_DIV_RDBK_EN
  logic [WIDTH-1:0] rd_div_q, rd_div_d;
  logic [WIDTH-1:0] rd_count_q, rd_count_d;
  logic             rd_pend_q, rd_pend_d;

  always_comb begin
    rd_div_d   = '0;
    rd_count_d = '0;
    rd_pend_d  = 1'b0;
    for (int unsigned c = 0; c < CHANNELS; c++) begin
      if (RD_CH == CH_BITS'(c)) begin
        rd_div_d   = div_q[c];
        rd_count_d = count_q[c];
        rd_pend_d  = pflag_q[c];
      end
    end
  end

  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      rd_div_q   <= '0;
      rd_count_q <= '0;
      rd_pend_q  <= 1'b0;
    end else begin
      rd_div_q   <= rd_div_d;
      rd_count_q <= rd_count_d;
      rd_pend_q  <= rd_pend_d;
    end
  end

  assign RD_DIV   = rd_div_q;
  assign RD_COUNT = rd_count_q;
  assign RD_PEND  = rd_pend_q;
`endif

endmodule

// File: tb/tb_clk_div_multi.sv
// Directed self-checking bench for clk_div_multi (3 channels, 8-bit, DEFAULT_DIV=3).
module tb_clk_div_multi;

  logic       CLOCK = 1'b0;
  logic       RESET_N = 1'b0;
  logic [2:0] EN;
  logic       SYNC;
  logic       WR_EN;
  logic [1:0] WR_CH;
  logic [7:0] WR_DATA;
  logic [2:0] SLOW;
  logic [2:0] TICK;
`ifdef CLK_DIV_RDBK_EN
  logic [1:0] RD_CH;
  logic [7:0] RD_DIV;
  logic [7:0] RD_COUNT;
  logic       RD_PEND;
`endif

  int unsigned checks = 0;
  int unsigned errors = 0;

  clk_div_multi #(
    .CHANNELS   (3),
    .WIDTH      (8),
    .DEFAULT_DIV(3)
  ) dut (
    .CLOCK  (CLOCK),
    .RESET_N(RESET_N),
    .EN     (EN),
    .SYNC   (SYNC),
    .WR_EN  (WR_EN),
    .WR_CH  (WR_CH),
    .WR_DATA(WR_DATA),
    .SLOW   (SLOW),
    .TICK   (TICK)
`ifdef CLK_DIV_RDBK_EN
    ,
    .RD_CH   (RD_CH),
    .RD_DIV  (RD_DIV),
    .RD_COUNT(RD_COUNT),
    .RD_PEND (RD_PEND)
`endif
  );

  always #5 CLOCK = ~CLOCK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // {slow, tick} after k edges of a channel that started at count 0 with slow=s0
  function automatic logic [1:0] exp_bits(input int k, input int d, input logic s0);
    return {s0 ^ 1'((k / (d + 1)) % 2), 1'((k % (d + 1)) == 0)};
  endfunction

  task automatic step();
    @(posedge CLOCK);
    @(negedge CLOCK);
  endtask

  task automatic check_out(input string tag, input int k,
                           input logic [1:0] e0, input logic [1:0] e1, input logic [1:0] e2);
    check($sformatf("%s_slow_k%0d", tag, k), {29'd0, SLOW}, {29'd0, e2[1], e1[1], e0[1]});
    check($sformatf("%s_tick_k%0d", tag, k), {29'd0, TICK}, {29'd0, e2[0], e1[0], e0[0]});
  endtask

  initial begin
    EN      = 3'b111;
    SYNC    = 1'b0;
    WR_EN   = 1'b0;
    WR_CH   = 2'd0;
    WR_DATA = 8'd0;
`ifdef CLK_DIV_RDBK_EN
    RD_CH   = 2'd1;
`endif
    #12;
    check("rst_slow", {29'd0, SLOW}, 32'd0);
    check("rst_tick", {29'd0, TICK}, 32'd0);
    @(negedge CLOCK);
    RESET_N = 1'b1;

    // Default divisor, then channel 1 reprogrammed to 1 while its count is 1
    for (int k = 1; k <= 28; k++) begin
      step();
      if (k <= 20)
        check_out("dflt", k, exp_bits(k, 3, 1'b0), exp_bits(k, 3, 1'b0), exp_bits(k, 3, 1'b0));
      else
        check_out("wr1", k, exp_bits(k, 3, 1'b0), exp_bits(k - 20, 1, 1'b1), exp_bits(k, 3, 1'b0));
`ifdef CLK_DIV_RDBK_EN
      if (k == 19 || k == 20) begin
        check($sformatf("rd_pend_k%0d", k), {31'd0, RD_PEND}, 32'd1);
        check($sformatf("rd_div_k%0d", k), {24'd0, RD_DIV}, 32'd3);
      end
      if (k == 21) begin
        check("rd_pend_k21", {31'd0, RD_PEND}, 32'd0);
        check("rd_div_k21", {24'd0, RD_DIV}, 32'd1);
      end
`endif
      if (k == 17) begin
        WR_EN = 1'b1; WR_CH = 2'd1; WR_DATA = 8'd1;
      end
      if (k == 18) WR_EN = 1'b0;
    end

    // DIV=0 on channel 0 applied through SYNC; then freeze channel 0
    WR_EN = 1'b1; WR_CH = 2'd0; WR_DATA = 8'd0;
    step();
    WR_EN = 1'b0; SYNC = 1'b1;
    step();
    check("sync1_slow", {29'd0, SLOW}, 32'd0);
    check("sync1_tick", {29'd0, TICK}, 32'd0);
    SYNC = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      step();
      check_out("div0", k, (k >= 10) ? 2'b10 : exp_bits(k, 0, 1'b0),
                exp_bits(k, 1, 1'b0), exp_bits(k, 3, 1'b0));
      if (k == 9) EN = 3'b110;
    end

    // Out-of-range write must not touch any channel
    EN = 3'b111; WR_EN = 1'b1; WR_CH = 2'd3; WR_DATA = 8'd0;
    step();
    WR_EN = 1'b0; SYNC = 1'b1;
`ifdef CLK_DIV_RDBK_EN
    RD_CH = 2'd3;
`endif
    step();
    check("sync2_slow", {29'd0, SLOW}, 32'd0);
    check("sync2_tick", {29'd0, TICK}, 32'd0);
    SYNC = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      step();
      check_out("oor", k, exp_bits(k, 0, 1'b0), exp_bits(k, 1, 1'b0), exp_bits(k, 3, 1'b0));
`ifdef CLK_DIV_RDBK_EN
      if (k == 2) begin
        check("rd_oor_div", {24'd0, RD_DIV}, 32'd0);
        check("rd_oor_cnt", {24'd0, RD_COUNT}, 32'd0);
        check("rd_oor_pend", {31'd0, RD_PEND}, 32'd0);
      end
`endif
    end
`ifdef CLK_DIV_RDBK_EN
    RD_CH = 2'd1;
`endif

    // SYNC with a same-cycle write: write stays pending until channel 2's next terminal count
    SYNC = 1'b1; WR_EN = 1'b1; WR_CH = 2'd2; WR_DATA = 8'd0;
    step();
    check("sync3_slow", {29'd0, SLOW}, 32'd0);
    check("sync3_tick", {29'd0, TICK}, 32'd0);
    SYNC = 1'b0; WR_EN = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      step();
      check_out("syncwr", k, exp_bits(k, 0, 1'b0), exp_bits(k, 1, 1'b0),
                (k <= 4) ? exp_bits(k, 3, 1'b0) : exp_bits(k - 4, 0, 1'b1));
    end

    // Asynchronous reset mid-cycle discards a pending write
    WR_EN = 1'b1; WR_CH = 2'd1; WR_DATA = 8'd0;
    @(posedge CLOCK);
    #1;
    WR_EN = 1'b0;
    check("pre_rst_tick0", {31'd0, TICK[0]}, 32'd1);
    #2;
    RESET_N = 1'b0;
    #1;
    check("arst_slow", {29'd0, SLOW}, 32'd0);
    check("arst_tick", {29'd0, TICK}, 32'd0);
`ifdef CLK_DIV_RDBK_EN
    check("arst_rd_div", {24'd0, RD_DIV}, 32'd0);
`endif
    @(negedge CLOCK);
    RESET_N = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      step();
      check_out("postrst", k, exp_bits(k, 3, 1'b0), exp_bits(k, 3, 1'b0), exp_bits(k, 3, 1'b0));
`ifdef CLK_DIV_RDBK_EN
      check($sformatf("rd_cnt_k%0d", k), {24'd0, RD_COUNT}, (k - 1) % 4);
      check($sformatf("rd_div_pr_k%0d", k), {24'd0, RD_DIV}, 32'd3);
      check($sformatf("rd_pend_pr_k%0d", k), {31'd0, RD_PEND}, 32'd0);
`endif
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
